// File: rtl/ibex_pmp_csr_file_if.sv
// ---------------------------------------------------------------------------
// ibex_pmp_csr_file_if
// Single-cycle CSR access port between the CSR block and the PMP CSR file.
//   csr_we     : write strobe, at most one write per cycle
//   csr_addr   : 12-bit CSR address, used for both read and write
//   csr_wdata  : write data
//   csr_rdata  : combinational read data for csr_addr
//   csr_illegal: combinational, csr_addr is not a PMP CSR handled here
// The CSR block uses the master modport, the PMP CSR file the slave modport.
// ---------------------------------------------------------------------------
interface ibex_pmp_csr_file_if;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_we,
    output csr_addr,
    output csr_wdata,
    input  csr_rdata,
    input  csr_illegal
  );

  modport slave (
    input  csr_we,
    input  csr_addr,
    input  csr_wdata,
    output csr_rdata,
    output csr_illegal
  );
endinterface

// File: rtl/ibex_pmp_csr_file.sv
// ---------------------------------------------------------------------------
// ibex_pkg (PMP subset)
// Shared PMP types consumed by the CSR file and the PMP access checker.
// ---------------------------------------------------------------------------
package ibex_pkg;
  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;
endpackage

// ---------------------------------------------------------------------------
// ibex_pmp_csr_file
// Architectural PMP state (pmpcfg, pmpaddr, mseccfg) with all WARL, lock and
// Smepmp write rules. Feeds the PMP access checker directly.
//
// Ports:
//   clk_i             : clock
//   rst_i             : synchronous active-high reset
//   csr_bus           : CSR access port (slave side), see ibex_pmp_csr_file_if
//   csr_pmp_cfg_o     : registered cfg per implemented entry
//   csr_pmp_addr_o    : {pmpaddr[31:0], 2'b00} per implemented entry
//   csr_pmp_mseccfg_o : registered {rlb, mmwp, mml}
//
// Parameters:
//   PMPGranularity : granule G, must match the checker instance
//   PMPNumRegions  : implemented entries (1..16); the rest read 0, ignore writes
// ---------------------------------------------------------------------------
module ibex_pmp_csr_file
  import ibex_pkg::*;
#(
  parameter int PMPGranularity = 0,
  parameter int PMPNumRegions  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ibex_pmp_csr_file_if.slave    csr_bus,
  output pmp_cfg_t              csr_pmp_cfg_o  [PMPNumRegions],
  output logic [33:0]           csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t          csr_pmp_mseccfg_o
);

  localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
  localparam logic [11:0] CSR_MSECCFG   = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

  pmp_cfg_t     cfg_q  [PMPNumRegions];
  pmp_cfg_t     cfg_d  [PMPNumRegions];
  logic [31:0]  addr_q [PMPNumRegions];
  logic [31:0]  addr_d [PMPNumRegions];
  pmp_mseccfg_t mseccfg_q;
  pmp_mseccfg_t mseccfg_d;

  logic is_cfg;
  logic is_addr;
  logic is_mseccfg;
  logic is_mseccfgh;

  logic [PMPNumRegions-1:0] entry_locked;
  logic [PMPNumRegions-1:0] addr_locked;
  logic                     any_lock;
  logic                     rlb_writable;

  // pmpcfg0-3 occupy one aligned block of four, pmpaddr0-15 one block of 16.
  assign is_cfg      = (csr_bus.csr_addr[11:2] == CSR_PMPCFG0[11:2]);
  assign is_addr     = (csr_bus.csr_addr[11:4] == CSR_PMPADDR0[11:4]);
  assign is_mseccfg  = (csr_bus.csr_addr == CSR_MSECCFG);
  assign is_mseccfgh = (csr_bus.csr_addr == CSR_MSECCFGH);

  assign csr_bus.csr_illegal = ~(is_cfg | is_addr | is_mseccfg | is_mseccfgh);

  // An entry is locked unless rule-locking bypass is active. pmpaddr[i] is
  // additionally frozen when entry i+1 is a locked TOR region, since
  // pmpaddr[i] forms its lower bound.
  for (genvar i = 0; i < PMPNumRegions; i++) begin : g_lock
    assign entry_locked[i] = cfg_q[i].lock & ~mseccfg_q.rlb;
    if (i < PMPNumRegions - 1) begin : g_tor
      assign addr_locked[i] = entry_locked[i] |
                              (entry_locked[i+1] & (cfg_q[i+1].mode == PMP_MODE_TOR));
    end else begin : g_last
      assign addr_locked[i] = entry_locked[i];
    end
  end

  always_comb begin
    any_lock = 1'b0;
    for (int i = 0; i < PMPNumRegions; i++) begin
      any_lock = any_lock | cfg_q[i].lock;
    end
  end

  // RLB may change while it is set, or before any entry has been locked.
  // Once MML is on with RLB off, RLB can never come back.
  assign rlb_writable = mseccfg_q.rlb | (~any_lock & ~mseccfg_q.mml);

  // Byte layout of a cfg entry inside a pmpcfg word.
  function automatic logic [7:0] pack_cfg(pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

  // Encodings that would create an M-mode executable region under MML:
  // any X=1 without W (001/101), and the locked W-only shared encoding.
  // 011 (shared) and 111+L (shared read-only) are allowed.
  function automatic logic mml_exec_region(pmp_cfg_t c);
    return (c.exec & ~c.write) | (~c.read & c.write & ~c.exec);
  endfunction

  // WARL legalisation of one written cfg byte against the old value.
  function automatic pmp_cfg_t warl_cfg(pmp_cfg_t old_cfg, logic [7:0] wbyte,
                                        pmp_mseccfg_t sec);
    pmp_cfg_t n;
    n.lock  = wbyte[7];
    n.mode  = pmp_cfg_mode_e'(wbyte[4:3]);
    n.exec  = wbyte[2];
    n.write = wbyte[1];
    n.read  = wbyte[0];
    // NA4 cannot be represented when the granule exceeds four bytes.
    if ((n.mode == PMP_MODE_NA4) && (PMPGranularity >= 1)) begin
      n.mode = old_cfg.mode;
    end
    // R=0,W=1 is reserved outside MML.
    if (~n.read & n.write & ~sec.mml) begin
      n.write = 1'b0;
    end
    // Locked M-mode executable regions are refused outright under MML.
    if (sec.mml & ~sec.rlb & n.lock & mml_exec_region(n)) begin
      n = old_cfg;
    end
    return n;
  endfunction

  // Granule-aware pmpaddr readback: NAPOT fills the low G-1 bits with ones,
  // OFF/TOR hide the low G bits. The stored value itself is never touched.
  function automatic logic [31:0] addr_readback(logic [31:0] a, pmp_cfg_mode_e mode);
    logic [31:0] r;
    r = a;
    for (int b = 0; b < 32; b++) begin
      if ((mode == PMP_MODE_NAPOT) && (PMPGranularity >= 2) && (b < PMPGranularity - 1)) begin
        r[b] = 1'b1;
      end
      if (((mode == PMP_MODE_OFF) || (mode == PMP_MODE_TOR)) && (b < PMPGranularity)) begin
        r[b] = 1'b0;
      end
    end
    return r;
  endfunction

  // Combinational readback; unimplemented entries contribute nothing.
  always_comb begin
    csr_bus.csr_rdata = 32'h0;
    for (int i = 0; i < PMPNumRegions; i++) begin
      if (is_cfg && (int'(csr_bus.csr_addr[1:0]) == i / 4)) begin
        csr_bus.csr_rdata[8*(i%4) +: 8] = pack_cfg(cfg_q[i]);
      end
      if (is_addr && (int'(csr_bus.csr_addr[3:0]) == i)) begin
        csr_bus.csr_rdata = addr_readback(addr_q[i], cfg_q[i].mode);
      end
    end
    if (is_mseccfg) begin
      csr_bus.csr_rdata = {29'h0, mseccfg_q.rlb, mseccfg_q.mmwp, mseccfg_q.mml};
    end
  end

  // Next-state for every register, honouring locks and WARL rules.
  always_comb begin
    mseccfg_d = mseccfg_q;
    for (int i = 0; i < PMPNumRegions; i++) begin
      cfg_d[i]  = cfg_q[i];
      addr_d[i] = addr_q[i];
    end

    if (csr_bus.csr_we) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (is_cfg && (int'(csr_bus.csr_addr[1:0]) == i / 4) && !entry_locked[i]) begin
          cfg_d[i] = warl_cfg(cfg_q[i], csr_bus.csr_wdata[8*(i%4) +: 8], mseccfg_q);
        end
        if (is_addr && (int'(csr_bus.csr_addr[3:0]) == i) && !addr_locked[i]) begin
          addr_d[i] = csr_bus.csr_wdata;
        end
      end
      if (is_mseccfg) begin
        // MML and MMWP are sticky until reset.
        mseccfg_d.mml  = mseccfg_q.mml  | csr_bus.csr_wdata[0];
        mseccfg_d.mmwp = mseccfg_q.mmwp | csr_bus.csr_wdata[1];
        if (rlb_writable) begin
          mseccfg_d.rlb = csr_bus.csr_wdata[2];
        end
      end
    end
  end

  // State registers; reset takes priority over a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        cfg_q[i]  <= '{lock: 1'b0, mode: PMP_MODE_OFF, exec: 1'b0, write: 1'b0, read: 1'b0};
        addr_q[i] <= 32'h0;
      end
      mseccfg_q <= '0;
    end else begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        cfg_q[i]  <= cfg_d[i];
        addr_q[i] <= addr_d[i];
      end
      mseccfg_q <= mseccfg_d;
    end
  end

  for (genvar i = 0; i < PMPNumRegions; i++) begin : g_out
    assign csr_pmp_cfg_o[i]  = cfg_q[i];
    assign csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
  end

  assign csr_pmp_mseccfg_o = mseccfg_q;

endmodule

// File: tb/tb_ibex_pmp_csr_file.sv
// ---------------------------------------------------------------------------
// tb_ibex_pmp_csr_file
// Directed bench for ibex_pmp_csr_file with granule G=2 and four entries.
// Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_ibex_pmp_csr_file;
  import ibex_pkg::*;

  localparam int G = 2;
  localparam int N = 4;

  logic clk_i;
  logic rst_i;

  ibex_pmp_csr_file_if bus_if ();

  pmp_cfg_t     cfg_o   [N];
  logic [33:0]  addr_o  [N];
  pmp_mseccfg_t msec_o;

  int check_count;
  int error_count;

  ibex_pmp_csr_file #(
    .PMPGranularity (G),
    .PMPNumRegions  (N)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .csr_bus           (bus_if),
    .csr_pmp_cfg_o     (cfg_o),
    .csr_pmp_addr_o    (addr_o),
    .csr_pmp_mseccfg_o (msec_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare and count one observation.
  task automatic checkOutput(input string tag, input logic [33:0] observed,
                             input logic [33:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle CSR write; inputs change #1 after the clock edge.
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
    bus_if.csr_we    = 1'b1;
    bus_if.csr_addr  = addr;
    bus_if.csr_wdata = data;
    @(posedge clk_i);
    #1;
    bus_if.csr_we    = 1'b0;
  endtask

  // Read a CSR mid-cycle and compare against a constant.
  task automatic checkRead(input string tag, input logic [11:0] addr,
                           input logic [31:0] expected);
    bus_if.csr_addr = addr;
    #1;
    checkOutput(tag, {2'b00, bus_if.csr_rdata}, {2'b00, expected});
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    check_count      = 0;
    error_count      = 0;
    rst_i            = 1'b0;
    bus_if.csr_we    = 1'b0;
    bus_if.csr_addr  = 12'h0;
    bus_if.csr_wdata = 32'h0;
    @(posedge clk_i);
    #1;
    doReset();

    // Reset state
    checkRead("rst_cfg0", 12'h3A0, 32'h0);
    checkRead("rst_addr0", 12'h3B0, 32'h0);
    checkRead("rst_msec", 12'h747, 32'h0);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst_cfg_o%0d", i), {28'h0, cfg_o[i]}, 34'h0);
      checkOutput($sformatf("rst_addr_o%0d", i), addr_o[i], 34'h0);
    end
    bus_if.csr_addr = 12'h3A0;
    #1;
    checkOutput("legal_3a0", {33'h0, bus_if.csr_illegal}, 34'h0);

    // Entry lock and TOR lower-bound lock
    applyStimulus(12'h3B1, 32'h0000_1000);
    applyStimulus(12'h3A0, 32'h0000_8F00);
    checkRead("lock_cfg0", 12'h3A0, 32'h0000_8F00);
    checkOutput("lock_cfg_o1", {28'h0, cfg_o[1]}, 34'h2F);
    checkOutput("lock_addr_o1", addr_o[1], 34'h4000);
    bus_if.csr_we    = 1'b1;
    bus_if.csr_addr  = 12'h3B1;
    bus_if.csr_wdata = 32'h0000_2000;
    #1;
    checkOutput("old_in_write", {2'b00, bus_if.csr_rdata}, 34'h1000);
    @(posedge clk_i);
    #1;
    bus_if.csr_we = 1'b0;
    checkRead("lock_addr1", 12'h3B1, 32'h0000_1000);
    applyStimulus(12'h3B0, 32'h0000_0055);
    checkRead("tor_addr0", 12'h3B0, 32'h0);
    applyStimulus(12'h3A0, 32'h0000_0000);
    checkRead("lock_keep", 12'h3A0, 32'h0000_8F00);

    // cfg WARL with MML off
    doReset();
    applyStimulus(12'h3A0, 32'h0000_001A);
    checkRead("warl_w_only", 12'h3A0, 32'h0000_0018);
    applyStimulus(12'h3A0, 32'h0000_001E);
    checkRead("warl_wx", 12'h3A0, 32'h0000_001C);

    // Granule readback and NA4 retention
    doReset();
    applyStimulus(12'h3B0, 32'hFFFF_FFFF);
    checkRead("g_off_rd", 12'h3B0, 32'hFFFF_FFFC);
    checkOutput("g_addr_o0", addr_o[0], 34'h3_FFFF_FFFC);
    applyStimulus(12'h3A0, 32'h0000_0018);
    checkRead("g_napot_rd", 12'h3B0, 32'hFFFF_FFFF);
    checkOutput("g_napot_o0", addr_o[0], 34'h3_FFFF_FFFC);
    applyStimulus(12'h3A0, 32'h0000_0010);
    checkRead("g_na4_keep", 12'h3A0, 32'h0000_0018);

    // MML rules
    doReset();
    applyStimulus(12'h747, 32'h1);
    checkRead("mml_set", 12'h747, 32'h1);
    checkOutput("mml_o", {31'h0, msec_o}, 34'h1);
    applyStimulus(12'h3A0, 32'h0000_009C);
    checkRead("mml_drop", 12'h3A0, 32'h0);
    applyStimulus(12'h3A0, 32'h0000_009F);
    checkRead("mml_shared_ro", 12'h3A0, 32'h0000_009F);
    applyStimulus(12'h747, 32'h0);
    checkRead("mml_sticky", 12'h747, 32'h1);
    applyStimulus(12'h747, 32'h4);
    checkRead("rlb_blocked", 12'h747, 32'h1);
    checkRead("msech_rd", 12'h757, 32'h0);

    // Rule-locking bypass
    doReset();
    applyStimulus(12'h747, 32'h4);
    checkRead("rlb_set", 12'h747, 32'h4);
    applyStimulus(12'h3A0, 32'h0000_008F);
    checkRead("rlb_lock_wr", 12'h3A0, 32'h0000_008F);
    applyStimulus(12'h3A0, 32'h0000_0003);
    checkRead("rlb_bypass", 12'h3A0, 32'h0000_0003);
    applyStimulus(12'h747, 32'h0);
    checkRead("rlb_clear", 12'h747, 32'h0);

    // Reset beats a same-cycle write
    applyStimulus(12'h3B2, 32'h0000_ABCD);
    checkRead("addr2_rd", 12'h3B2, 32'h0000_ABCC);
    rst_i            = 1'b1;
    bus_if.csr_we    = 1'b1;
    bus_if.csr_addr  = 12'h3B2;
    bus_if.csr_wdata = 32'h0000_1234;
    @(posedge clk_i);
    #1;
    rst_i         = 1'b0;
    bus_if.csr_we = 1'b0;
    checkRead("rst_wins", 12'h3B2, 32'h0);
    checkOutput("rst_wins_o", addr_o[2], 34'h0);

    // Illegal address and unimplemented entry
    bus_if.csr_we    = 1'b1;
    bus_if.csr_addr  = 12'h3A4;
    bus_if.csr_wdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("illegal_3a4", {33'h0, bus_if.csr_illegal}, 34'h1);
    checkOutput("illegal_rd", {2'b00, bus_if.csr_rdata}, 34'h0);
    @(posedge clk_i);
    #1;
    bus_if.csr_we = 1'b0;
    checkRead("illegal_nochg", 12'h3A0, 32'h0);
    applyStimulus(12'h3BF, 32'h1234_5678);
    checkRead("unimpl_addr", 12'h3BF, 32'h0);
    checkOutput("unimpl_legal", {33'h0, bus_if.csr_illegal}, 34'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_csr_file.md
Name: ibex_pmp_csr_file

Overview:
Holds the architectural PMP state (pmpcfg, pmpaddr, mseccfg) and applies all WARL, lock and Smepmp write rules. Sits directly upstream of the PMP access checker and drives its csr_pmp_cfg / csr_pmp_addr / csr_pmp_mseccfg inputs. Written and read through a single-cycle CSR port from the CSR block.

Parameters:
PMPGranularity, 0, NAPOT/TOR granule G; must match the checker instance.
PMPNumRegions, 4, implemented entries, 1..16; unimplemented entries read 0 and ignore writes.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
csr_we_i  in  1  write strobe, one write per cycle
csr_addr_i  in  12  CSR address for read and write
csr_wdata_i  in  32  write data
csr_rdata_o  out  32  combinational read data for csr_addr_i
csr_illegal_o  out  1  combinational; csr_addr_i is not a PMP CSR handled here
csr_pmp_cfg_o  out  ibex_pkg::pmp_cfg_t[PMPNumRegions]  registered cfg per entry
csr_pmp_addr_o  out  34[PMPNumRegions]  {pmpaddr[31:0], 2'b00}
csr_pmp_mseccfg_o  out  ibex_pkg::pmp_mseccfg_t  registered {rlb, mmwp, mml}

Behaviour:
- Address map: pmpcfg0-3 = 0x3A0-0x3A3, 4 entries per word, entry i in byte i%4 as {L[7], 00[6:5], A[4:3], X[2], W[1], R[0]}; pmpaddr0-15 = 0x3B0-0x3BF; mseccfg = 0x747 {RLB[2], MMWP[1], MML[0]}; mseccfgh = 0x757 reads 0, writes ignored. Other addresses: csr_illegal_o=1, rdata 0.
- Reset (rst_i sampled high at clk_i edge): all cfg 0 (mode OFF), all addr 0, mseccfg 0. Outputs show reset values the cycle after the reset edge. Reset wins over a simultaneous write.
- Latency: a write accepted at edge N is visible on all outputs and on csr_rdata_o after edge N. Reading the same address in the write cycle returns the old value.
- Entry lock: locked(i) = cfg[i].L & ~mseccfg.RLB. A write to a locked cfg byte leaves that byte unchanged; other bytes in the word update normally.
- Addr lock: pmpaddr[i] is unwritable if locked(i), or if locked(i+1) and cfg[i+1].A==TOR.
- cfg WARL, per byte, applied in order:
  - bits[6:5] stored 0.
  - A==NA4 with G>=1: mode field keeps its old value; the remaining fields still write.
  - R=0,W=1 with MML=0: stored R=0,W=0,X as written.
  - MML=1 and RLB=0: a write with L=1 that yields an M-mode executable region is dropped whole-byte. This covers X=1 except the {R=0,W=1,X=1} shared encoding, and {R,W,X,L}={0,1,0,1}. Exception: {R,W,X,L}={1,1,1,1} shared read-only is allowed.
- pmpaddr storage: bits[31:0] stored. Bits [33:2] of csr_pmp_addr_o come straight from the register.
- pmpaddr readback, G>=1:
  - NAPOT entries read bits[G-2:0] as 1 (only when G>=2).
  - OFF/TOR entries read bits[G-1:0] as 0.
  - The stored value is unchanged either way.
- mseccfg:
  - MML and MMWP are sticky: a write can set them, only reset clears them.
  - RLB is writable only when RLB is currently 1, or when no entry has L=1. Once MML=1 and RLB=0, RLB cannot be set again.
  - MMWP/MML set and an RLB clear in the same write all apply.
- A cfg write and a lock-dependent addr check never occur in the same cycle (single write port). Addr lock always uses the current registered cfg.

Test Plan:
- Reset, then read 0x3A0, 0x3B0, 0x747 -> all 0; csr_pmp_cfg_o all OFF; csr_pmp_addr_o all 0.
- Write pmpaddr1=0x0000_1000, then pmpcfg0=0x0000_8F00 (entry1 TOR, L, RWX) -> cfg1 locked. A further write of pmpaddr1 or pmpaddr0 keeps 0x1000 and 0. A write of pmpcfg0=0x0000_0000 leaves entry1 byte 0x8F.
- MML=0: write pmpcfg0 byte0=0x1A (NAPOT, W only, X=0) -> reads 0x18. Write 0x1E (NAPOT, W, X) -> reads 0x1C.
- G=2: write pmpaddr0=0xFFFF_FFFF with entry0 OFF -> reads 0xFFFF_FFFC. Set NAPOT -> reads 0xFFFF_FFFF; csr_pmp_addr_o[0]=34'h3_FFFF_FFFC. Write NA4 -> mode stays NAPOT.
- Write mseccfg=0x1 (MML), then pmpcfg0 byte0=0x9C (L, NAPOT, X) -> byte dropped, reads 0. Byte0=0x9F -> accepted, reads 0x9F. Write mseccfg=0 -> MML still 1.
- Write with rst_i high in the same cycle -> all state 0 next cycle. Write to 0x3A4 -> csr_illegal_o=1, no state change.
